// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   arb_state_e : FSM encoding IDLE=0, ISSUE=1, WAIT=2, RESP=3
//   PORT_CPU/LDR: bit index of each requester in the grant vector
//   GNT_*       : one-hot grant constants
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LDR  = 2'b10;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: winner selection for the two memory requesters.
// Build option MEM_ARB_RR_EN: when defined, round-robin between the ports
// (loader wins the first tie after reset); otherwise fixed CPU priority with
// a saturating starvation counter that hands the loader the grant once it
// has lost STARVE_MAX arbitrations in a row.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cpu_req, ldr_req  pending requests
//   load              an arbitration is being taken this cycle
//   win               one-hot winner (combinational)
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       ldr_req,
  input  logic       load,
  output logic [1:0] win
);

`ifdef MEM_ARB_RR_EN
  // Set when the loader owned the previous grant; reset value means the CPU
  // counts as last served, so the loader takes the first tie.
  logic last_ldr;

  always_comb begin
    win = GNT_NONE;
    if (cpu_req && ldr_req) win = last_ldr ? GNT_CPU : GNT_LDR;
    else if (cpu_req)       win = GNT_CPU;
    else if (ldr_req)       win = GNT_LDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_ldr <= 1'b0;
    else if (load) last_ldr <= win[PORT_LDR];
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    win = GNT_NONE;
    if (ldr_req && (!cpu_req || starve_cnt == CNT_MAX)) win = GNT_LDR;
    else if (cpu_req)                                   win = GNT_CPU;
  end

  // Counts lost arbitrations only; a loader-less arbitration leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else if (load) begin
      if (win == GNT_LDR)                     starve_cnt <= '0;
      else if (ldr_req && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between the CPU (port 0) and the boot
// loader/DMA (port 1), one transaction at a time. Read and write both take
// MEM_LAT+1 cycles from the arbitrating IDLE cycle to the ack.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see arb_pick).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_/ldr_ req, we, addr, wdata     requests, held until ack
//   cpu_ack, ldr_ack                   one-cycle completion pulses
//   rdata                              read data, valid with an ack, else 0
//   mem_en, mem_we, mem_addr, mem_wdata memory strobes (ISSUE cycle only)
//   mem_rdata                          memory read data
//   grant                              one-hot owner, bit0 CPU, bit1 loader
//   busy                               FSM is not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              cpu_ack,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int WCNT_W = $clog2(MEM_LAT + 1);
  // WAIT occupies MEM_LAT-1 cycles; the count starts at 1 on entry.
  localparam logic [WCNT_W-1:0] WCNT_FIRST = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(MEM_LAT - 1);

  arb_state_e        state;
  logic [WCNT_W-1:0] wcnt;
  logic [1:0]        win;
  logic              load;

  assign load  = (state == IDLE) && (cpu_req || ldr_req);
  assign busy  = (state != IDLE);
  assign rdata = (cpu_ack || ldr_ack) ? mem_rdata : '0;

  arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .load    (load),
    .win     (win)
  );

  // Outputs are registered on the transition into the state they belong to,
  // so mem_en is high exactly during ISSUE and the ack exactly during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      wcnt      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state  <= ISSUE;
          grant  <= win;
          mem_en <= 1'b1;
          if (win[PORT_LDR]) begin
            mem_we    <= ldr_we;
            mem_addr  <= ldr_addr;
            mem_wdata <= ldr_wdata;
          end else begin
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            state <= WAIT;
            wcnt  <= WCNT_FIRST;
          end else begin
            state   <= RESP;
            cpu_ack <= grant[PORT_CPU];
            ldr_ack <= grant[PORT_LDR];
          end
        end
        WAIT: begin
          if (wcnt == WCNT_LAST) begin
            state   <= RESP;
            wcnt    <= '0;
            cpu_ack <= grant[PORT_CPU];
            ldr_ack <= grant[PORT_LDR];
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each
// with its own requesters and a small behavioural memory.
module tb_mem_port_arbiter;
  localparam int N = 3;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        cpu_req [N], ldr_req [N], cpu_we [N], ldr_we [N];
  logic [31:0] cpu_addr [N], ldr_addr [N], cpu_wdata [N], ldr_wdata [N];
  logic        cpu_ack [N], ldr_ack [N], mem_en [N], mem_we [N], busy [N];
  logic [31:0] mem_addr [N], mem_wdata [N], rdata [N];
  logic [1:0]  grant [N];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234_5678 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mq;
    // Memory captures data on the strobe and holds it, so data is valid
    // from one cycle after mem_en onward.
    always @(posedge clk) if (mem_en[g]) mq <= memf(mem_addr[g]);
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(STARVE_MAX)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]), .ldr_wdata(ldr_wdata[g]),
      .cpu_ack(cpu_ack[g]), .ldr_ack(ldr_ack[g]), .rdata(rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mq), .grant(grant[g]), .busy(busy[g])
    );
  end

  task automatic clr(input int i);
    cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
    ldr_req[i] = 0; ldr_we[i] = 0; ldr_addr[i] = 0; ldr_wdata[i] = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    for (int i = 0; i < N; i++) clr(i);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    logic [103:0] got;
    rst_n = 0;
    for (int i = 0; i < N; i++) clr(i);
    #1;
    for (int i = 0; i < N; i++) begin
      got = {grant[i], cpu_ack[i], ldr_ack[i], mem_en[i], mem_we[i], busy[i], mem_addr[i], mem_wdata[i], rdata[i]};
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_outputs inst%0d: got %h want 0", i, got); end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_cpu_read;
    logic [36:0] got, exp;
    do_reset();
    @(negedge clk);                        // cycle 0
    cpu_req[1] = 1; cpu_addr[1] = 32'h40; cpu_we[1] = 0; cpu_wdata[1] = 32'hFFFF_0000;
    @(negedge clk);                        // cycle 1
    got = {mem_en[1], mem_we[1], grant[1], busy[1], mem_addr[1]};
    exp = {1'b1, 1'b0, 2'b01, 1'b1, 32'h40};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL cpu_read_issue: got %h want %h", got, exp); end
    @(negedge clk);                        // cycle 2
    checks++;
    if ({mem_en[1], cpu_ack[1], ldr_ack[1]} !== 3'b000) begin
      errors++; $display("FAIL cpu_read_wait: got %b want 000", {mem_en[1], cpu_ack[1], ldr_ack[1]});
    end
    @(negedge clk);                        // cycle 3
    checks++;
    if ({cpu_ack[1], ldr_ack[1], rdata[1]} !== {2'b10, 32'h1234_5678}) begin
      errors++; $display("FAIL cpu_read_ack: got %h want %h", {cpu_ack[1], ldr_ack[1], rdata[1]}, {2'b10, 32'h1234_5678});
    end
    cpu_req[1] = 0;
    @(negedge clk);                        // cycle 4
    got = {cpu_ack[1], grant[1], busy[1], 1'b0, mem_addr[1]};
    exp = {1'b0, 2'b00, 1'b0, 1'b0, 32'h40};
    checks++;
    if (got !== exp || rdata[1] !== 32'h0) begin
      errors++; $display("FAIL cpu_read_done: got %h rdata %h want %h rdata 0", got, rdata[1], exp);
    end
  endtask

  task automatic test_ldr_write;
    logic [67:0] got, exp;
    do_reset();
    @(negedge clk);
    ldr_req[0] = 1; ldr_we[0] = 1; ldr_addr[0] = 32'h100; ldr_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);                        // cycle 1
    got = {mem_en[0], mem_we[0], grant[0], mem_addr[0], mem_wdata[0]};
    exp = {1'b1, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ldr_write_issue: got %h want %h", got, exp); end
    @(negedge clk);                        // cycle 2
    checks++;
    if ({ldr_ack[0], cpu_ack[0], mem_en[0], mem_we[0]} !== 4'b1000) begin
      errors++; $display("FAIL ldr_write_ack: got %b want 1000", {ldr_ack[0], cpu_ack[0], mem_en[0], mem_we[0]});
    end
    ldr_req[0] = 0;
    @(negedge clk);                        // cycle 3
    got = {ldr_ack[0], busy[0], 2'b00, mem_addr[0], mem_wdata[0]};
    exp = {1'b0, 1'b0, 2'b00, 32'h100, 32'hDEAD_BEEF};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ldr_write_hold: got %h want %h", got, exp); end
  endtask

  task automatic test_both;
    int f;
    logic [1:0] g1, g2;
    logic [31:0] a1, a2;
`ifdef MEM_ARB_RR_EN
    f = 1;
`else
    f = 0;
`endif
    g1 = f ? 2'b10 : 2'b01;
    g2 = ~g1;
    a1 = f ? 32'h300 : 32'h200;
    a2 = f ? 32'h200 : 32'h300;
    do_reset();
    @(negedge clk);
    cpu_req[0] = 1; cpu_addr[0] = 32'h200; ldr_req[0] = 1; ldr_addr[0] = 32'h300;
    @(negedge clk);                        // cycle 1
    checks++;
    if (grant[0] !== g1 || mem_addr[0] !== a1) begin
      errors++; $display("FAIL both_first_grant: got %b/%h want %b/%h", grant[0], mem_addr[0], g1, a1);
    end
    @(negedge clk);                        // cycle 2
    checks++;
    if ({ldr_ack[0], cpu_ack[0]} !== g1 || rdata[0] !== memf(a1)) begin
      errors++; $display("FAIL both_first_ack: got %b/%h want %b/%h", {ldr_ack[0], cpu_ack[0]}, rdata[0], g1, memf(a1));
    end
    if (f == 1) ldr_req[0] = 0; else cpu_req[0] = 0;
    @(negedge clk);                        // cycle 3: IDLE, arbitration
    checks++;
    if ({busy[0], grant[0], cpu_ack[0], ldr_ack[0]} !== 5'b0) begin
      errors++; $display("FAIL both_idle: got %b want 00000", {busy[0], grant[0], cpu_ack[0], ldr_ack[0]});
    end
    @(negedge clk);                        // cycle 4
    checks++;
    if (grant[0] !== g2 || mem_en[0] !== 1'b1 || mem_addr[0] !== a2) begin
      errors++; $display("FAIL both_second_grant: got %b/%b/%h want %b/1/%h", grant[0], mem_en[0], mem_addr[0], g2, a2);
    end
    @(negedge clk);                        // cycle 5
    checks++;
    if ({ldr_ack[0], cpu_ack[0]} !== g2 || rdata[0] !== memf(a2)) begin
      errors++; $display("FAIL both_second_ack: got %b/%h want %b/%h", {ldr_ack[0], cpu_ack[0]}, rdata[0], g2, memf(a2));
    end
    cpu_req[0] = 0; ldr_req[0] = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    logic [9:0] ldr_wins;
    int n;
`ifdef MEM_ARB_RR_EN
    ldr_wins = 10'b01_0101_0101;
`else
    ldr_wins = 10'b10_0001_0000;
`endif
    do_reset();
    @(negedge clk);
    cpu_req[0] = 1; cpu_addr[0] = 32'h10; ldr_req[0] = 1; ldr_addr[0] = 32'h20;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (mem_en[0] !== 1'b1 && n < 12);
      checks++;
      if (mem_en[0] !== 1'b1 || grant[0] !== (ldr_wins[k] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starvation_arb%0d: mem_en=%b grant=%b want mem_en=1 grant=%b", k + 1, mem_en[0], grant[0],
                 ldr_wins[k] ? 2'b10 : 2'b01);
      end
    end
    cpu_req[0] = 0; ldr_req[0] = 0;
    n = 0;
    while (busy[0] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [103:0] got;
    do_reset();
    @(negedge clk);                        // cycle 0
    cpu_req[2] = 1; cpu_addr[2] = 32'h80;
    @(negedge clk);                        // cycle 1
    checks++;
    if (mem_en[2] !== 1'b1) begin errors++; $display("FAIL rstmid_issue: mem_en=%b want 1", mem_en[2]); end
    @(negedge clk);                        // cycle 2: WAIT
    rst_n = 0;
    #1;
    got = {grant[2], cpu_ack[2], ldr_ack[2], mem_en[2], mem_we[2], busy[2], mem_addr[2], mem_wdata[2], rdata[2]};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", got); end
    @(negedge clk);
    checks++;
    if ({cpu_ack[2], busy[2]} !== 2'b00) begin
      errors++; $display("FAIL rstmid_noack: got %b want 00", {cpu_ack[2], busy[2]});
    end
    rst_n = 1;                             // first IDLE cycle after release
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      checks++;
      if ({mem_en[2], cpu_ack[2]} !== {j == 1, j == 4}) begin
        errors++; $display("FAIL rstmid_cycle%0d: got %b want %b", j, {mem_en[2], cpu_ack[2]}, {j == 1, j == 4});
      end
      if (j == 4) begin
        checks++;
        if (rdata[2] !== memf(32'h80)) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", rdata[2], memf(32'h80)); end
        cpu_req[2] = 0;
      end
    end
  endtask

  // Transaction-level model: a transaction owns the memory from its
  // arbitration until its ack, MEM_LAT+1 cycles later; phase counts cycles
  // into that window (0 = idle).
  task automatic test_random(input int i, input int ncyc);
    int L, phase, owner, starve;
    bit last_ldr;
    bit pend [2];
    logic m_we;
    logic [31:0] m_addr, m_wdata;
    logic [103:0] got, exp;
    L = i + 1; phase = 0; owner = 0; starve = 0; last_ldr = 0;
    pend[0] = 0; pend[1] = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      got = {grant[i], cpu_ack[i], ldr_ack[i], mem_en[i], mem_we[i], busy[i], rdata[i], mem_addr[i], mem_wdata[i]};
      exp = {(phase != 0) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00,
             phase == L + 1 && owner == 0, phase == L + 1 && owner == 1,
             phase == 1, phase == 1 && m_we, phase != 0,
             (phase == L + 1) ? memf(m_addr) : 32'h0, m_addr, m_wdata};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random inst%0d cyc%0d: got %h want %h", i, cyc, got, exp); end
      for (int p = 0; p < 2; p++) begin
        if (phase == L + 1 && owner == p) pend[p] = 0;
        if (!pend[p] && cyc < ncyc - 12 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          if (p == 0) begin
            cpu_we[i] = 1'($urandom); cpu_addr[i] = $urandom & 32'hFFFC; cpu_wdata[i] = $urandom;
          end else begin
            ldr_we[i] = 1'($urandom); ldr_addr[i] = $urandom & 32'hFFFC; ldr_wdata[i] = $urandom;
          end
        end
      end
      cpu_req[i] = pend[0];
      ldr_req[i] = pend[1];
      if (phase == 0) begin
        if (pend[0] || pend[1]) begin
`ifdef MEM_ARB_RR_EN
          owner = (pend[0] && pend[1]) ? (last_ldr ? 0 : 1) : (pend[1] ? 1 : 0);
          last_ldr = (owner == 1);
`else
          owner = (pend[1] && (!pend[0] || starve == STARVE_MAX)) ? 1 : 0;
          if (owner == 1) starve = 0;
          else if (pend[1] && starve < STARVE_MAX) starve++;
`endif
          m_we    = owner ? ldr_we[i]    : cpu_we[i];
          m_addr  = owner ? ldr_addr[i]  : cpu_addr[i];
          m_wdata = owner ? ldr_wdata[i] : cpu_wdata[i];
          phase = 1;
        end
      end else if (phase == L + 1) phase = 0;
      else phase++;
    end
    clr(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_both();
    test_starvation();
    test_reset_mid();
    for (int i = 0; i < N; i++) test_random(i, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
